// File: rtl/dsp_mac_pipe_pkg.sv
// dsp_mac_pipe_pkg: OPMODE bit positions, X/Z select codes and B source names for the MAC slice.
package dsp_mac_pipe_pkg;
  localparam int OP_X = 0;
  localparam int OP_Z = 2;
  localparam int OP_PRE_SEL = 4;
  localparam int OP_CIN = 5;
  localparam int OP_PRE_SUB = 6;
  localparam int OP_POST_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M = 2'd1;
  localparam logic [1:0] X_P = 2'd2;
  localparam logic [1:0] X_DAB = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P = 2'd2;
  localparam logic [1:0] Z_C = 2'd3;
  localparam string B_DIRECT = "DIRECT";
  localparam string B_CASCADE = "CASCADE";
endpackage

// File: rtl/dsp_mac_pipe_if.sv
// dsp_mac_pipe_if: operand/result stream bundle of the MAC slice; master = producer/consumer, slave = slice.
interface dsp_mac_pipe_if #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int CW = 48,
  parameter int PW = 48
);
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic [BW-1:0] bcin;
  logic [BW-1:0] d;
  logic [CW-1:0] c;
  logic [PW-1:0] pcin;
  logic [7:0] opmode;
  logic carryin;
  logic acc_clr;
  logic out_valid;
  logic out_ready;
  logic [PW-1:0] p;
  logic [PW-1:0] pcout;
  logic [AW+BW-1:0] m;
  logic [BW-1:0] bcout;
  logic carryout;
  modport master (
    output in_valid, a, b, bcin, d, c, pcin, opmode, carryin, acc_clr, out_ready,
    input in_ready, out_valid, p, pcout, m, bcout, carryout
  );
  modport slave (
    input in_valid, a, b, bcin, d, c, pcin, opmode, carryin, acc_clr, out_ready,
    output in_ready, out_valid, p, pcout, m, bcout, carryout
  );
endinterface

// File: rtl/dsp_mac_pipe_reg.sv
// dsp_pipe_reg: enabled register with asynchronous active-low clear, one per pipeline field.
module dsp_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage pre-add/multiply/post-add MAC with valid/ready stall; DSP_MAC_SAT_EN enables unsigned P saturation.
module dsp_mac_pipe
  import dsp_mac_pipe_pkg::*;
#(
  parameter int    AW = 18,
  parameter int    BW = 18,
  parameter int    CW = 48,
  parameter int    PW = 48,
  parameter string B_INPUT = B_DIRECT
) (
  input logic clk,
  input logic rst_n,
  dsp_mac_pipe_if.slave bus
);
  localparam int MW = AW + BW;
  logic adv, v0, v1, v2, ov, cin, sub;
  logic [AW-1:0] a0, a1, a2;
  logic [BW-1:0] b0, b1, b2, d0, d1, d2, pre;
  logic [CW-1:0] c0, c1, c2;
  logic [9:0] k0;
  logic [7:0] op0, k1, k2;
  logic [MW-1:0] m;
  logic [PW-1:0] p, pfb, x, z, p_nxt;
  logic [PW-1:0] xv [4];
  logic [PW-1:0] zv [4];
  logic [PW:0] sum;
  logic co;
  // The whole pipe stalls as one unit, so a held result never gets overwritten.
  assign adv = !ov || bus.out_ready;
  assign bus.in_ready = adv;
  assign op0 = k0[9:2];
  dsp_pipe_reg #(1)  u_v0 (.clk, .rst_n, .en(adv), .d(bus.in_valid), .q(v0));
  dsp_pipe_reg #(AW) u_a0 (.clk, .rst_n, .en(adv), .d(bus.a), .q(a0));
  dsp_pipe_reg #(BW) u_b0 (.clk, .rst_n, .en(adv), .d(B_INPUT == B_CASCADE ? bus.bcin : bus.b), .q(b0));
  dsp_pipe_reg #(BW) u_d0 (.clk, .rst_n, .en(adv), .d(bus.d), .q(d0));
  dsp_pipe_reg #(CW) u_c0 (.clk, .rst_n, .en(adv), .d(bus.c), .q(c0));
  dsp_pipe_reg #(10) u_k0 (.clk, .rst_n, .en(adv), .d({bus.opmode, bus.carryin, bus.acc_clr}), .q(k0));
  assign pre = op0[OP_PRE_SUB] ? d0 - b0 : d0 + b0;
  dsp_pipe_reg #(1)  u_v1 (.clk, .rst_n, .en(adv), .d(v0), .q(v1));
  dsp_pipe_reg #(AW) u_a1 (.clk, .rst_n, .en(adv), .d(a0), .q(a1));
  dsp_pipe_reg #(BW) u_b1 (.clk, .rst_n, .en(adv), .d(op0[OP_PRE_SEL] ? pre : b0), .q(b1));
  dsp_pipe_reg #(BW) u_d1 (.clk, .rst_n, .en(adv), .d(d0), .q(d1));
  dsp_pipe_reg #(CW) u_c1 (.clk, .rst_n, .en(adv), .d(c0), .q(c1));
  // Only the fields still needed by the post-adder travel past stage 1.
  dsp_pipe_reg #(8)  u_k1 (.clk, .rst_n, .en(adv),
    .d({op0[OP_POST_SUB], op0[OP_CIN], op0[OP_Z+:2], op0[OP_X+:2], k0[1:0]}), .q(k1));
  dsp_pipe_reg #(1)  u_v2 (.clk, .rst_n, .en(adv), .d(v1), .q(v2));
  dsp_pipe_reg #(MW) u_m  (.clk, .rst_n, .en(adv), .d(MW'(a1) * MW'(b1)), .q(m));
  dsp_pipe_reg #(AW) u_a2 (.clk, .rst_n, .en(adv), .d(a1), .q(a2));
  dsp_pipe_reg #(BW) u_b2 (.clk, .rst_n, .en(adv), .d(b1), .q(b2));
  dsp_pipe_reg #(BW) u_d2 (.clk, .rst_n, .en(adv), .d(d1), .q(d2));
  dsp_pipe_reg #(CW) u_c2 (.clk, .rst_n, .en(adv), .d(c1), .q(c2));
  dsp_pipe_reg #(8)  u_k2 (.clk, .rst_n, .en(adv), .d(k1), .q(k2));
  always_comb begin
    pfb = k2[0] ? '0 : p;
    xv[X_ZERO] = '0;
    xv[X_M] = PW'(m);
    xv[X_P] = pfb;
    xv[X_DAB] = PW'({d2, a2, b2});
    zv[Z_ZERO] = '0;
    zv[Z_PCIN] = bus.pcin;
    zv[Z_P] = pfb;
    zv[Z_C] = PW'(c2);
    x = xv[k2[3:2]];
    z = zv[k2[5:4]];
    cin = k2[6] | k2[1];
    sub = k2[7];
    sum = sub ? {1'b0, z} - ({1'b0, x} + (PW+1)'(cin)) : {1'b0, z} + {1'b0, x} + (PW+1)'(cin);
`ifdef DSP_MAC_SAT_EN
    p_nxt = sum[PW] ? (sub ? '0 : '1) : sum[PW-1:0];
`else
    p_nxt = sum[PW-1:0];
`endif
  end
  // P only moves on a valid beat, so bubbles leave the accumulator intact.
  dsp_pipe_reg #(PW+1) u_p  (.clk, .rst_n, .en(adv && v2), .d({sum[PW], p_nxt}), .q({co, p}));
  dsp_pipe_reg #(1)    u_ov (.clk, .rst_n, .en(adv), .d(v2), .q(ov));
  assign bus.out_valid = ov;
  assign bus.p = p;
  assign bus.pcout = p;
  assign bus.carryout = co;
  assign bus.m = m;
  assign bus.bcout = b1;
endmodule
